// File: rtl/c_arith_pkg.sv
// Shared arithmetic definitions: add/sub mode encodings, result flag payload
// and legal parameter ranges for the add/sub pipeline.
package c_arith_pkg;

  localparam int unsigned W_MIN      = 2;
  localparam int unsigned W_MAX      = 32;
  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 4;

  // Operation select: wrap vs. saturate, add vs. subtract.
  typedef enum logic [1:0] {
    ADD_WRAP = 2'b00,
    SUB_WRAP = 2'b01,
    SUB_SAT  = 2'b10,
    ADD_SAT  = 2'b11
  } mode_e;

  // Status flags travelling alongside each result.
  typedef struct packed {
    logic cy;    // carry (add) or borrow (sub) out of bit W-1
    logic sat;   // result was clamped
    logic zero;  // result is all zeros
  } flags_t;

endpackage

// File: rtl/c_addsub_core.sv
// Stateless W-bit add/subtract with wrap or saturate behaviour.
// Ports:
//   a, b     operands
//   mode     operation select (mode_e encoding)
//   s_c      result (combinational)
//   flags_c  carry/borrow, saturated, zero flags (combinational)
module c_addsub_core
  import c_arith_pkg::*;
#(
  parameter int unsigned W = 15
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   mode,
  output logic [W-1:0] s_c,
  output flags_t       flags_c
);

  // One extra bit captures carry-out of the sum and borrow of the difference.
  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Mode selection and clamping.
  always_comb begin
    s_c     = sum[W-1:0];
    flags_c = '0;
    case (mode_e'(mode))
      ADD_WRAP: begin
        s_c        = sum[W-1:0];
        flags_c.cy = sum[W];
      end
      SUB_WRAP: begin
        s_c        = diff[W-1:0];
        flags_c.cy = diff[W];
      end
      SUB_SAT: begin
        flags_c.cy = diff[W];
        if (diff[W]) begin
          s_c         = '0;
          flags_c.sat = 1'b1;
        end else begin
          s_c = diff[W-1:0];
        end
      end
      ADD_SAT: begin
        flags_c.cy = sum[W];
        if (sum[W]) begin
          s_c         = '1;
          flags_c.sat = 1'b1;
        end else begin
          s_c = sum[W-1:0];
        end
      end
      default: ;
    endcase
    flags_c.zero = (s_c == '0);
  end

endmodule

// File: rtl/c_addsub_pipe.sv
// Valid/ready pipelined add/subtract unit with wrap and saturate modes.
// Arithmetic is done combinationally ahead of the first register; the
// remaining stages are plain register slots. The whole pipe stalls as one
// when the output is held.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake (in_ready is combinational)
//   in_a, in_b, in_mode   operands and operation select
//   out_valid/out_ready   output handshake
//   out_s, out_cy, out_sat, out_zero   registered result and flags
module c_addsub_pipe
  import c_arith_pkg::*;
#(
  parameter int unsigned W      = 15,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_s,
  output logic         out_cy,
  output logic         out_sat,
  output logic         out_zero
);

  // Elaboration-time parameter range checks.
  if (W < W_MIN || W > W_MAX) begin : g_bad_w
    $error("c_addsub_pipe: W=%0d outside legal range 2..32", W);
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("c_addsub_pipe: STAGES=%0d outside legal range 1..4", STAGES);
  end

  logic         advance;
  logic [W-1:0] core_s;
  flags_t       core_f;

  // Per-slot next values (d) and registers (q).
  logic         v_d [STAGES];
  logic [W-1:0] s_d [STAGES];
  flags_t       f_d [STAGES];
  logic         v_q [STAGES];
  logic [W-1:0] s_q [STAGES];
  flags_t       f_q [STAGES];

  // Global stall: move when the output slot is empty or being drained.
  assign advance  = out_ready || !v_q[STAGES-1];
  assign in_ready = advance;

  c_addsub_core #(.W(W)) u_core (
    .a       (in_a),
    .b       (in_b),
    .mode    (in_mode),
    .s_c     (core_s),
    .flags_c (core_f)
  );

  // First slot is fed by the arithmetic core.
  assign v_d[0] = in_valid;
  assign s_d[0] = core_s;
  assign f_d[0] = core_f;

  // Later slots are fed by their predecessor.
  for (genvar i = 1; i < STAGES; i++) begin : g_link
    assign v_d[i] = v_q[i-1];
    assign s_d[i] = s_q[i-1];
    assign f_d[i] = f_q[i-1];
  end

  // Register slots; data of an invalid slot is carried but never observed.
  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[i] <= 1'b0;
        s_q[i] <= '0;
        f_q[i] <= '0;
      end else if (advance) begin
        v_q[i] <= v_d[i];
        s_q[i] <= s_d[i];
        f_q[i] <= f_d[i];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_s     = s_q[STAGES-1];
  assign out_cy    = f_q[STAGES-1].cy;
  assign out_sat   = f_q[STAGES-1].sat;
  assign out_zero  = f_q[STAGES-1].zero;

endmodule

// File: tb/tb_c_addsub_pipe.sv
// Directed and swept checks of the add/sub pipeline at STAGES=2, 1 and 4.
module tb_c_addsub_pipe;
  import c_arith_pkg::*;

  localparam int unsigned TW = 15;
  localparam int unsigned NSW = 30;

  typedef struct packed {
    logic [TW-1:0] s;
    logic          cy;
    logic          sat;
    logic          zero;
  } res_t;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic [1:0]    mode;
    res_t          exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (STAGES=2)
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [TW-1:0] in_a, in_b, out_s;
  logic [1:0]    in_mode;
  logic          out_cy, out_sat, out_zero;

  c_addsub_pipe #(.W(TW), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_cy(out_cy), .out_sat(out_sat), .out_zero(out_zero)
  );

  // Sweep DUTs: index 0 -> STAGES=1, index 1 -> STAGES=4
  logic          sw_rst_n;
  logic          sw_valid [2];
  logic          sw_iready [2];
  logic [TW-1:0] sw_a [2];
  logic [TW-1:0] sw_b [2];
  logic [1:0]    sw_mode [2];
  logic          sw_ovalid [2];
  logic          sw_oready [2];
  logic [TW-1:0] sw_s [2];
  logic          sw_cy [2];
  logic          sw_sat [2];
  logic          sw_zero [2];

  c_addsub_pipe #(.W(TW), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(sw_rst_n),
    .in_valid(sw_valid[0]), .in_ready(sw_iready[0]),
    .in_a(sw_a[0]), .in_b(sw_b[0]), .in_mode(sw_mode[0]),
    .out_valid(sw_ovalid[0]), .out_ready(sw_oready[0]),
    .out_s(sw_s[0]), .out_cy(sw_cy[0]), .out_sat(sw_sat[0]), .out_zero(sw_zero[0])
  );

  c_addsub_pipe #(.W(TW), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(sw_rst_n),
    .in_valid(sw_valid[1]), .in_ready(sw_iready[1]),
    .in_a(sw_a[1]), .in_b(sw_b[1]), .in_mode(sw_mode[1]),
    .out_valid(sw_ovalid[1]), .out_ready(sw_oready[1]),
    .out_s(sw_s[1]), .out_cy(sw_cy[1]), .out_sat(sw_sat[1]), .out_zero(sw_zero[1])
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model written in integer arithmetic.
  function automatic res_t model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                 input logic [1:0] mode);
    int unsigned ia, ib, mx;
    res_t r;
    ia = 32'(a);
    ib = 32'(b);
    mx = (32'd1 << TW) - 32'd1;
    r  = '0;
    case (mode)
      2'd0: begin r.cy = (ia + ib) > mx; r.s = TW'(ia + ib); end
      2'd1: begin r.cy = ib > ia;        r.s = TW'(ia - ib); end
      2'd2: begin
        if (ib > ia) begin r.cy = 1'b1; r.sat = 1'b1; r.s = '0; end
        else r.s = TW'(ia - ib);
      end
      default: begin
        if ((ia + ib) > mx) begin r.cy = 1'b1; r.sat = 1'b1; r.s = TW'(mx); end
        else r.s = TW'(ia + ib);
      end
    endcase
    r.zero = (r.s == '0);
    return r;
  endfunction

  function automatic vec_t mk(input logic [TW-1:0] a, input logic [TW-1:0] b,
                              input logic [1:0] m, input logic [TW-1:0] s,
                              input logic cy, input logic sat, input logic zero);
    vec_t v;
    v.a = a; v.b = b; v.mode = m;
    v.exp.s = s; v.exp.cy = cy; v.exp.sat = sat; v.exp.zero = zero;
    return v;
  endfunction

  task automatic run_sweep(input int w, input int lat);
    logic [TW-1:0] a [NSW];
    logic [TW-1:0] b [NSW];
    logic [1:0]    m [NSW];
    int            issue [NSW];
    int            sent, recv;
    sent = 0;
    recv = 0;
    for (int i = 0; i < NSW; i++) begin
      a[i] = TW'($urandom);
      b[i] = TW'($urandom);
      m[i] = 2'($urandom_range(3, 0));
      issue[i] = 0;
    end
    a[0] = 15'h7FFF; b[0] = 15'h0001; m[0] = 2'd3;
    a[1] = 15'h0003; b[1] = 15'h0009; m[1] = 2'd2;
    a[2] = 15'h0042; b[2] = 15'h0042; m[2] = 2'd2;
    sw_oready[w] = 1'b1;
    for (int cyc = 0; cyc < int'(NSW) + lat + 6; cyc++) begin
      @(posedge clk); #1;
      sw_valid[w] = (sent < int'(NSW));
      if (sent < int'(NSW)) begin
        sw_a[w] = a[sent]; sw_b[w] = b[sent]; sw_mode[w] = m[sent];
      end
      @(negedge clk);
      if (sw_ovalid[w]) begin
        if (recv < int'(NSW)) begin
          check($sformatf("sweep%0d_res[%0d]", lat, recv),
                32'({sw_s[w], sw_cy[w], sw_sat[w], sw_zero[w]}),
                32'(model(a[recv], b[recv], m[recv])));
          check($sformatf("sweep%0d_lat[%0d]", lat, recv), 32'(cyc - issue[recv]), 32'(lat));
          recv++;
        end else begin
          tests++;
          fails++;
          $display("FAIL sweep%0d_extra: got an unexpected beat, expected none", lat);
        end
      end
      if (sw_valid[w] && sw_iready[w]) begin
        issue[sent] = cyc;
        sent++;
      end
    end
    sw_valid[w] = 1'b0;
    check($sformatf("sweep%0d_count", lat), 32'(recv), 32'(NSW));
  endtask

  vec_t          vt [11];
  logic [TW-1:0] sa [8];
  logic [TW-1:0] sb [8];
  logic [1:0]    sm [8];

  initial begin
    int   sent, recv, nout;
    logic have_hold;
    res_t held, cres;

    rst_n = 1'b0; sw_rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sw_valid[i] = 1'b0; sw_a[i] = '0; sw_b[i] = '0; sw_mode[i] = '0; sw_oready[i] = 1'b1;
    end

    vt[0]  = mk(15'h0005, 15'h0007, 2'd1, 15'h7FFE, 1'b1, 1'b0, 1'b0);
    vt[1]  = mk(15'h0005, 15'h0007, 2'd2, 15'h0000, 1'b1, 1'b1, 1'b1);
    vt[2]  = mk(15'h1234, 15'h1234, 2'd2, 15'h0000, 1'b0, 1'b0, 1'b1);
    vt[3]  = mk(15'h7FFF, 15'h0001, 2'd3, 15'h7FFF, 1'b1, 1'b1, 1'b0);
    vt[4]  = mk(15'h7FFF, 15'h0001, 2'd0, 15'h0000, 1'b1, 1'b0, 1'b1);
    vt[5]  = mk(15'h7000, 15'h0FFF, 2'd3, 15'h7FFF, 1'b0, 1'b0, 1'b0);
    vt[6]  = mk(15'h1234, 15'h0111, 2'd0, 15'h1345, 1'b0, 1'b0, 1'b0);
    vt[7]  = mk(15'h0007, 15'h0005, 2'd1, 15'h0002, 1'b0, 1'b0, 1'b0);
    vt[8]  = mk(15'h0007, 15'h0005, 2'd2, 15'h0002, 1'b0, 1'b0, 1'b0);
    vt[9]  = mk(15'h4000, 15'h4000, 2'd3, 15'h7FFF, 1'b1, 1'b1, 1'b0);
    vt[10] = mk(15'h1234, 15'h1234, 2'd1, 15'h0000, 1'b0, 1'b0, 1'b1);

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_outputs", 32'({out_s, out_cy, out_sat, out_zero}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; sw_rst_n = 1'b1;

    // Single-beat directed vectors, latency 2
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = vt[i].a; in_b = vt[i].b; in_mode = vt[i].mode;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_early_valid", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_result", i), 32'({out_s, out_cy, out_sat, out_zero}),
            32'(vt[i].exp));
      @(posedge clk);
    end

    // 8-beat stream with out_ready low in cycles 3..5
    for (int k = 0; k < 8; k++) begin
      sa[k] = TW'(32'h0F00 * k + 32'h0123);
      sb[k] = TW'(32'h1357 * (k + 1));
      sm[k] = 2'(k);
    end
    sent = 0; recv = 0; have_hold = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(posedge clk); #1;
      in_valid = (sent < 8);
      if (sent < 8) begin in_a = sa[sent]; in_b = sb[sent]; in_mode = sm[sent]; end
      out_ready = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      if (have_hold) begin
        check($sformatf("stall_valid_c%0d", cyc), 32'(out_valid), 32'd1);
        check($sformatf("stall_stable_c%0d", cyc), 32'({out_s, out_cy, out_sat, out_zero}),
              32'(held));
        have_hold = 1'b0;
      end
      if (out_valid && !out_ready) begin
        check($sformatf("stall_in_ready_c%0d", cyc), 32'(in_ready), 32'd0);
        held = {out_s, out_cy, out_sat, out_zero};
        have_hold = 1'b1;
      end
      if (out_valid && out_ready) begin
        check($sformatf("pass_in_ready_c%0d", cyc), 32'(in_ready), 32'd1);
        if (recv < 8)
          check($sformatf("stream_res[%0d]", recv), 32'({out_s, out_cy, out_sat, out_zero}),
                32'(model(sa[recv], sb[recv], sm[recv])));
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", 32'(recv), 32'd8);

    // Asynchronous reset with two beats in flight
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 15'h0100; in_b = 15'h0001; in_mode = 2'd0;
    @(posedge clk); #1;
    in_a = 15'h0200; in_b = 15'h0002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inflight_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_out_s", 32'(out_s), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_a = 15'h0ABC; in_b = 15'h0123; in_mode = 2'd1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cres = model(15'h0ABC, 15'h0123, 2'd1);
    nout = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid) begin
        nout++;
        check("post_rst_res", 32'({out_s, out_cy, out_sat, out_zero}), 32'(cres));
      end
    end
    check("post_rst_beats", 32'(nout), 32'd1);

    // Sweeps at STAGES=1 and STAGES=4
    run_sweep(0, 1);
    run_sweep(1, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
